tdm_mux8: RTL and testbench

- 8:1 time-division multiplexer and serializer.
- Scans eight 1-bit data inputs onto one serial line, one slot at a time.
- Drives slot-select lines s2..s0 so the far end can route each bit with a 1:8 demultiplexer.
- Sits at the transmit end of the team's TDM link; the dmux8 structure is the receive end.

---
 rtl/tdm_mux8_pkg.sv | 28 ++
 rtl/tdm_mux8_tick_gen.sv | 41 ++++
 rtl/tdm_mux8.sv | 146 ++++++++++++++
 tb/tb_tdm_mux8.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tdm_mux8_pkg.sv
// -----------------------------------------------------------------------------
// tdm_mux8_pkg
// Shared definitions for the 8:1 TDM serializer (tdm_mux8) and its prescaler
// (tdm_tick_gen): slot counts, FSM state encoding and slot-counter sizing.
//
// Build option: define TDM_PARITY_EN to append a ninth (even-parity) slot
// after slot 7. The slot counter then widens from 3 to 4 bits.
// -----------------------------------------------------------------------------
package tdm_mux8_pkg;

    localparam int TDM_SLOTS    = 8;   // data slots per frame
    localparam int TDM_SLOT_W   = 3;   // width of the s2..s0 slot-select bus
    localparam int TDM_PAR_SLOT = 8;   // index of the optional parity slot

    typedef enum logic {
        TDM_IDLE = 1'b0,
        TDM_RUN  = 1'b1
    } tdm_state_e;

`ifdef TDM_PARITY_EN
    localparam int TDM_CNT_W     = 4;
    localparam int TDM_LAST_SLOT = TDM_PAR_SLOT;
`else
    localparam int TDM_CNT_W     = TDM_SLOT_W;
    localparam int TDM_LAST_SLOT = TDM_SLOTS - 1;
`endif

endpackage

// File: rtl/tdm_mux8_tick_gen.sv
// -----------------------------------------------------------------------------
// tdm_tick_gen
// Slot prescaler. Counts enabled cycles and pulses tick on the last cycle of
// each slot, so a slot lasts exactly HOLD enabled cycles. With HOLD=1, tick
// simply follows en. The count holds while en is low.
//
// Parameters: HOLD  cycles per slot, 1..255 (8-bit prescaler)
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   en    in   count enable (scanner running and not paused)
//   tick  out  slot-advance strobe, combinational from en and the count
// -----------------------------------------------------------------------------
module tdm_tick_gen #(
    parameter int unsigned HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(HOLD - 1);

    logic [7:0] r_cnt;

    assign tick = en && (r_cnt == TERM);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of its neighbours regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/tdm_mux8.sv
// -----------------------------------------------------------------------------
// tdm_mux8
// Transmit end of the TDM link: snapshots d7..d0 at each frame boundary and
// scans the snapshot onto z0 one slot at a time, with the slot number on
// s2..s0 so the far-end 1:8 demultiplexer can route each bit.
//
// Build option: TDM_PARITY_EN adds slot 8 carrying even parity of the
// snapshot (s2..s0 = 000, frame = 0) and the par_slot output.
//
// Parameters: HOLD  clock cycles per slot, 1..255
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   en            run enable; low before the first frame keeps the scanner
//                 idle, low mid-frame pauses it in place
//   d0..d7        parallel data channels (d0 goes out in slot 0)
//   z0            serial data
//   s0, s1, s2    current slot number, s0 = LSB
//   frame         high during slot 0 of each valid frame
//   valid         high while z0 and s2..s0 carry live data
//   par_slot      (TDM_PARITY_EN only) high during the parity slot
// All outputs decode registers only; d*/en never reach them combinationally.
// -----------------------------------------------------------------------------
module tdm_mux8
    import tdm_mux8_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    output logic z0,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic frame,
    output logic valid
`ifdef TDM_PARITY_EN
    ,
    output logic par_slot
`endif
);

    localparam logic [TDM_CNT_W-1:0] LAST_SLOT = TDM_CNT_W'(TDM_LAST_SLOT);

    tdm_state_e              r_state;
    tdm_state_e              w_state_nxt;
    logic [TDM_CNT_W-1:0]    r_slot;
    logic [TDM_SLOTS-1:0]    r_shadow;
    logic                    r_valid;

    logic [TDM_SLOTS-1:0]    w_data;
    logic                    w_start;
    logic                    w_run_en;
    logic                    w_tick;
    logic [TDM_SLOT_W-1:0]   w_sel;
    logic                    w_z;

    assign w_data   = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign w_start  = (r_state == TDM_IDLE) && en;
    // The prescaler only runs once a frame is live, so it is still zero on
    // the IDLE->RUN edge and slot 0 gets its full HOLD cycles.
    assign w_run_en = (r_state == TDM_RUN) && en;

    tdm_tick_gen #(
        .HOLD (HOLD)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run_en),
        .tick  (w_tick)
    );

    // FSM: IDLE until the first enabled edge, then RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TDM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            TDM_IDLE: if (en) w_state_nxt = TDM_RUN;
            TDM_RUN:  w_state_nxt = TDM_RUN;
            default:  w_state_nxt = TDM_IDLE;
        endcase
    end

    // Slot counter and frame snapshot. The shadow reloads only at frame
    // boundaries (start and last-slot wrap), so mid-frame d* changes are
    // invisible until the next frame. The shadow is a plain register bank and
    // is reset so z0 reads 0 before the first frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_shadow <= '0;
            r_valid  <= 1'b0;
        end else if (w_start) begin
            r_slot   <= '0;
            r_shadow <= w_data;
            r_valid  <= 1'b1;
        end else if (w_tick) begin
            if (r_slot == LAST_SLOT) begin
                r_slot   <= '0;
                r_shadow <= w_data;
            end else begin
                r_slot   <= r_slot + 1'b1;
            end
        end
    end

    // Output mux: data bit for the current slot, or parity in the extra slot.
    always_comb begin
        w_sel = r_slot[TDM_SLOT_W-1:0];
        w_z   = r_shadow[w_sel];
`ifdef TDM_PARITY_EN
        if (r_slot == TDM_CNT_W'(TDM_PAR_SLOT)) begin
            w_sel = '0;
            w_z   = ^r_shadow;
        end
`endif
    end

    assign z0    = w_z;
    assign s0    = w_sel[0];
    assign s1    = w_sel[1];
    assign s2    = w_sel[2];
    assign valid = r_valid;
    assign frame = r_valid && (r_slot == '0);
`ifdef TDM_PARITY_EN
    assign par_slot = r_valid && (r_slot == TDM_CNT_W'(TDM_PAR_SLOT));
`endif

endmodule

// File: tb/tb_tdm_mux8.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux8
// Directed bench for tdm_mux8. Three instances (HOLD = 1, 2, 3) share clock,
// reset and data; each has its own enable. Outputs are sampled on the falling
// edge and compared as one packed vector {valid, s2, s1, s0, z0, frame, par}
// against a slot model computed from the enabled-cycle count.
// Honours TDM_PARITY_EN (nine slots, parity bit, par_slot port).
// -----------------------------------------------------------------------------
module tb_tdm_mux8;

`ifdef TDM_PARITY_EN
    localparam int NSLOT = 9;
`else
    localparam int NSLOT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] en;
    logic [2:0] z, s0, s1, s2, fr, vl, ps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_mux8 #(.HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(en[0]),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .z0(z[0]), .s0(s0[0]), .s1(s1[0]), .s2(s2[0]),
        .frame(fr[0]), .valid(vl[0])
`ifdef TDM_PARITY_EN
        , .par_slot(ps[0])
`endif
    );

    tdm_mux8 #(.HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .en(en[1]),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .z0(z[1]), .s0(s0[1]), .s1(s1[1]), .s2(s2[1]),
        .frame(fr[1]), .valid(vl[1])
`ifdef TDM_PARITY_EN
        , .par_slot(ps[1])
`endif
    );

    tdm_mux8 #(.HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .en(en[2]),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .z0(z[2]), .s0(s0[2]), .s1(s1[2]), .s2(s2[2]),
        .frame(fr[2]), .valid(vl[2])
`ifdef TDM_PARITY_EN
        , .par_slot(ps[2])
`endif
    );

`ifndef TDM_PARITY_EN
    assign ps = 3'b000;
`endif

    // Expected {valid, s2..s0, z0, frame, par} for the c-th live cycle of an
    // instance with the given HOLD scanning snapshot dat.
    function automatic logic [6:0] exp_vec(input int h, input int c, input logic [7:0] dat);
        int sl;
        sl = (c / h) % NSLOT;
        if (sl == 8)
            return {1'b1, 3'b000, ^dat, 1'b0, 1'b1};
        return {1'b1, 3'(sl), dat[sl], (sl == 0), 1'b0};
    endfunction

    function automatic logic [6:0] obs(input int k);
        return {vl[k], s2[k], s1[k], s0[k], z[k], fr[k], ps[k]};
    endfunction

    task automatic check(input string tag, input int k, input logic [6:0] expv);
        logic [6:0] o;
        o = obs(k);
        checks++;
        assert (o === expv) else begin
            errors++;
            $error("FAIL %s dut%0d observed %b expected %b (v,s2,s1,s0,z0,frame,par)",
                   tag, k, o, expv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 3'b000;
        d     = 8'hA6;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset release with en low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) check("idle", k, 7'b0);
        end

        // 2 + 4: HOLD=1 continuous scan; d goes to FF in slot 3 of frame 2,
        // which must only show up from frame 3 onward
        en[0] = 1'b1;
        for (int c = 0; c < 4 * NSLOT; c++) begin
            @(negedge clk);
            check("h1_scan", 0, exp_vec(1, c, (c >= 3 * NSLOT) ? 8'hFF : 8'hA6));
            if (c == 2 * NSLOT + 3) d = 8'hFF;
        end

        // 3: HOLD=3, every slot held 3 cycles
        d     = 8'hA6;
        en[2] = 1'b1;
        for (int c = 0; c < 2 * 3 * NSLOT; c++) begin
            @(negedge clk);
            check("h3_scan", 2, exp_vec(3, c, 8'hA6));
        end

        // 5: HOLD=2, pause 4 cycles at the first cycle of slot 5
        en[1] = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            check("h2_scan", 1, exp_vec(2, c, 8'hA6));
        end
        en[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("h2_pause", 1, exp_vec(2, 10, 8'hA6));
        end
        en[1] = 1'b1;
        for (int c = 11; c <= 2 * (NSLOT + 4); c++) begin
            @(negedge clk);
            check("h2_resume", 1, exp_vec(2, c, 8'hA6));
        end

        // 6: reset in slot 4 (frame 2) with en still high; asynchronous clear
        d     = 8'h07;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check("rst_async", k, 7'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) check("rst_hold", k, 7'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * NSLOT; c++) begin
            @(negedge clk);
            check("post_rst_h1", 0, exp_vec(1, c, 8'h07));
            check("post_rst_h2", 1, exp_vec(2, c, 8'h07));
            check("post_rst_h3", 2, exp_vec(3, c, 8'h07));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
